// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences the shared HI/LO multiply/divide resource that sits beside the
//   E-stage ALU. It runs a fixed-latency multiply or a 32-step restoring
//   divide, owns the HI and LO registers, and asks the hazard unit to stall
//   while it is busy.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   reset    in   asynchronous active-low reset
//   startE   in   MULT/MULTU/DIV/DIVU valid in E
//   opE      in   [1:0] 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcaE    in   [31:0] rs operand (dividend / multiplicand, MTHI/MTLO data)
//   srcbE    in   [31:0] rt operand (divisor / multiplier)
//   mthiE    in   MTHI valid in E
//   mtloE    in   MTLO valid in E
//   mfhiE    in   MFHI valid in E
//   mfloE    in   MFLO valid in E
//   flushE   in   E-stage flush from the hazard unit
//   resultE  out  [31:0] mfhiE ? hi : lo
//   stallE   out  stall request to the hazard unit
//   busy     out  sequencer is not idle
//   done     out  one-cycle pulse after HI/LO were written by a mult/div
//   hi, lo   out  [31:0] HI and LO registers
//   stateDbg out  [1:0] current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
//
// Handshake: a request is taken on a rising edge when busy=0 and flushE=0.
// While busy, any request raises stallE and is held off by the pipeline;
// the operation already in flight always runs to completion.

module muldiv_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        mthiE,
  input  logic        mtloE,
  input  logic        mfhiE,
  input  logic        mfloE,
  input  logic        flushE,
  output logic [31:0] resultE,
  output logic        stallE,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  stateDbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  // opA holds the multiplicand, or the dividend that is shifted out while the
  // quotient bits are shifted in. opB holds the multiplier or the divisor.
  logic [31:0]      opA;
  logic [31:0]      opB;
  logic [31:0]      remReg;
  logic             mulSigned;
  logic             quoNeg;
  logic             remNeg;
  logic             divZero;

  logic             accept;
  logic             signedDiv;
  logic [31:0]      absA;
  logic [31:0]      absB;
  logic [63:0]      mulProd;
  logic [32:0]      remShift;
  logic [32:0]      trial;
  logic             stepOk;
  logic [31:0]      nextRem;
  logic [31:0]      nextQuo;
  logic [31:0]      fixQuo;
  logic [31:0]      fixRem;

  assign busy     = (state != IDLE);
  assign stallE   = busy & (startE | mfhiE | mfloE | mthiE | mtloE);
  assign accept   = ~busy & ~flushE;
  assign resultE  = mfhiE ? hi : lo;
  assign stateDbg = state;

  // Operand magnitudes for a signed divide; 0x80000000 maps onto itself,
  // which is the correct unsigned magnitude.
  assign signedDiv = ~opE[0];
  assign absA      = (signedDiv & srcaE[31]) ? -srcaE : srcaE;
  assign absB      = (signedDiv & srcbE[31]) ? -srcbE : srcbE;

  always_comb begin
    mulProd = 64'd0;
    if (mulSigned) begin
      mulProd = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
    end else begin
      mulProd = {32'd0, opA} * {32'd0, opB};
    end
  end

  // One restoring step: shift {rem, quo} left, try to subtract the divisor,
  // keep the difference only when it does not borrow.
  assign remShift = {remReg, opA[31]};
  assign trial    = remShift - {1'b0, opB};
  assign stepOk   = ~trial[32];
  assign nextRem  = stepOk ? trial[31:0] : remShift[31:0];
  assign nextQuo  = {opA[30:0], stepOk};

  // A zero divisor leaves the full |dividend| in the remainder, so the
  // remainder sign fix restores the original dividend; only the quotient
  // needs overriding.
  assign fixQuo = quoNeg ? -opA : opA;
  assign fixRem = remNeg ? -remReg : remReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opA       <= '0;
      opB       <= '0;
      remReg    <= '0;
      mulSigned <= 1'b0;
      quoNeg    <= 1'b0;
      remNeg    <= 1'b0;
      divZero   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (startE) begin
              if (!opE[1]) begin
                state     <= MUL;
                cnt       <= CNT_W'(MUL_LATENCY - 1);
                opA       <= srcaE;
                opB       <= srcbE;
                mulSigned <= ~opE[0];
              end else begin
                state   <= DIV;
                cnt     <= CNT_W'(31);
                opA     <= absA;
                opB     <= absB;
                remReg  <= '0;
                quoNeg  <= signedDiv & (srcaE[31] ^ srcbE[31]);
                remNeg  <= signedDiv & srcaE[31];
                divZero <= (srcbE == 32'd0);
              end
            end else begin
              if (mthiE) hi <= srcaE;
              if (mtloE) lo <= srcaE;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            hi    <= mulProd[63:32];
            lo    <= mulProd[31:0];
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          remReg <= nextRem;
          opA    <= nextQuo;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          hi    <= fixRem;
          lo    <= divZero ? 32'hFFFF_FFFF : fixQuo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
